// File: rtl/modport_bridge.sv
// Single-entry valid/ready bridge: accepts one request on the follower side and re-issues it on the master side.
// Optional completed-transfer counter enabled by MODPORT_BRIDGE_COUNTER_EN (counter port tied to 0 otherwise).
module modport_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] f_data,
  input  logic                  f_write_enable,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_write_enable,
  output logic [7:0]            data_out,
  output logic [1:0]            state,
  output logic [ID_WIDTH-1:0]   counter
);

  // Handshake: a transfer happens on a posedge where valid && ready are both high.
  // f_ready is only high in STATE_A; m_valid is only high in STATE_B, so m_ready
  // outside STATE_B is ignored.
  typedef enum logic [1:0] {
    STATE_A       = 2'd0,
    STATE_B       = 2'd1,
    STATE_C       = 2'd2,
    STATE_ILLEGAL = 2'd3
  } state_t;

  state_t state_q;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= STATE_A;
      f_ready        <= 1'b0;
      m_valid        <= 1'b0;
      m_addr         <= '0;
      m_data         <= '0;
      m_write_enable <= 1'b0;
      data_out       <= '0;
    end else begin
      case (state_q)
        STATE_A: begin
          if (f_valid && f_ready) begin
            m_addr         <= f_addr;
            m_data         <= f_data;
            m_write_enable <= f_write_enable;
            m_valid        <= 1'b1;
            f_ready        <= 1'b0;
            state_q        <= STATE_B;
            if (f_write_enable) begin
              data_out <= f_data[7:0];
            end
          end else begin
            // f_ready comes out of reset low and rises here on the first edge.
            f_ready <= 1'b1;
          end
        end
        STATE_B: begin
          if (m_ready) begin
            m_valid        <= 1'b0;
            m_write_enable <= 1'b0;
            state_q        <= STATE_C;
          end
        end
        STATE_C: begin
          f_ready <= 1'b1;
          state_q <= STATE_A;
        end
        default: begin
          m_valid <= 1'b0;
          f_ready <= 1'b1;
          state_q <= STATE_A;
        end
      endcase
    end
  end

`ifdef MODPORT_BRIDGE_COUNTER_EN
  logic xfer;

  assign xfer = (state_q == STATE_B) && m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
    end else if (xfer) begin
      counter <= counter + ID_WIDTH'(1);
    end
  end
`else
  assign counter = '0;
`endif

endmodule

// File: tb/tb_modport_bridge.sv
// Directed + randomized bench for modport_bridge: transaction-level model with an expected queue.
module tb_modport_bridge;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int W  = AW + DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_valid = 1'b0;
  logic          f_ready;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_data = '0;
  logic          f_write_enable = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_write_enable;
  logic [7:0]    data_out;
  logic [1:0]    state;
  logic [IW-1:0] counter;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_xfer   = 0;
  logic [7:0] model_dout = '0;
  logic [W-1:0] exp_q[$];

  modport_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_valid       (f_valid),
    .f_ready       (f_ready),
    .f_addr        (f_addr),
    .f_data        (f_data),
    .f_write_enable(f_write_enable),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_addr        (m_addr),
    .m_data        (m_data),
    .m_write_enable(m_write_enable),
    .data_out      (data_out),
    .state         (state),
    .counter       (counter)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Completed transfers modulo 2^IW, or 0 when the counter is compiled out.
  function automatic logic [IW-1:0] exp_counter();
`ifdef MODPORT_BRIDGE_COUNTER_EN
    return IW'(n_xfer % (1 << IW));
`else
    return '0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_f_ready();
    int k = 0;
    while (f_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("f_ready_wait", 64'(f_ready), 64'(1));
  endtask

  // Driver: one full transaction with 'stall' cycles of backpressure.
  task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                        input int stall, input bit garbage);
    f_valid = 1'b1;
    f_addr = a;
    f_data = d;
    f_write_enable = we;
    m_ready = 1'b0;
    wait_f_ready();
    step();
    exp_q.push_back({a, d, we});
    if (we) model_dout = d[7:0];
    f_valid = 1'b0;
    f_addr = $urandom;
    f_data = DW'($urandom);
    f_write_enable = 1'($urandom_range(0, 1));
    check("accept_m_valid", 64'(m_valid), 64'(1));
    check("accept_f_ready", 64'(f_ready), 64'(0));
    check("accept_state", 64'(state), 64'(1));
    check("accept_data_out", 64'(data_out), 64'(model_dout));
    for (int i = 0; i < stall; i++) begin
      if (garbage) f_valid = 1'($urandom_range(0, 1));
      step();
      check("stall_m_valid", 64'(m_valid), 64'(1));
      check("stall_fields", 64'({m_addr, m_data, m_write_enable}), 64'(exp_q[0]));
      check("stall_state", 64'(state), 64'(1));
      check("stall_f_ready", 64'(f_ready), 64'(0));
    end
    f_valid = 1'b0;
    m_ready = 1'b1;
    check("issue_fields", 64'({m_addr, m_data, m_write_enable}), 64'(exp_q[0]));
    step();
    void'(exp_q.pop_front());
    n_xfer++;
    m_ready = 1'($urandom_range(0, 1));
    check("xfer_m_valid", 64'(m_valid), 64'(0));
    check("xfer_m_we", 64'(m_write_enable), 64'(0));
    check("xfer_state", 64'(state), 64'(2));
    check("xfer_f_ready", 64'(f_ready), 64'(0));
    check("xfer_counter", 64'(counter), 64'(exp_counter()));
    step();
    check("turn_state", 64'(state), 64'(0));
    check("turn_f_ready", 64'(f_ready), 64'(1));
    check("turn_m_valid", 64'(m_valid), 64'(0));
    check("turn_data_out", 64'(data_out), 64'(model_dout));
    m_ready = 1'b0;
  endtask

  initial begin
    // Reset held for 3 cycles, all outputs low
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_f_ready", 64'(f_ready), 64'(0));
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_fields", 64'({m_addr, m_data, m_write_enable}), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));
      check("rst_state", 64'(state), 64'(0));
      check("rst_counter", 64'(counter), 64'(0));
    end
    rst = 1'b1;
    #1;
    check("release_f_ready_low", 64'(f_ready), 64'(0));
    step();
    check("release_f_ready", 64'(f_ready), 64'(1));
    check("release_state", 64'(state), 64'(0));

    // Directed: write, read, backpressured write
    do_txn(32'h10, 16'hBEEF, 1'b1, 0, 1'b0);
    check("write_data_out", 64'(data_out), 64'(8'hEF));
    do_txn(32'h44, 16'h1234, 1'b0, 0, 1'b0);
    check("read_data_out", 64'(data_out), 64'(8'hEF));
    do_txn(32'h20, 16'hCAFE, 1'b1, 5, 1'b1);

    // m_ready while idle has no effect
    m_ready = 1'b1;
    step();
    step();
    check("idle_m_valid", 64'(m_valid), 64'(0));
    check("idle_counter", 64'(counter), 64'(exp_counter()));
    m_ready = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      do_txn($urandom, DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end

    // Reset while in STATE_B abandons the request
    f_valid = 1'b1;
    f_addr = 32'hDEAD;
    f_data = 16'h5A5A;
    f_write_enable = 1'b1;
    wait_f_ready();
    step();
    f_valid = 1'b0;
    check("rstb_m_valid_before", 64'(m_valid), 64'(1));
    step();
    rst = 1'b0;
    #1;
    exp_q.delete();
    n_xfer = 0;
    model_dout = '0;
    check("rstb_m_valid", 64'(m_valid), 64'(0));
    check("rstb_counter", 64'(counter), 64'(0));
    check("rstb_state", 64'(state), 64'(0));
    check("rstb_data_out", 64'(data_out), 64'(0));
    step();
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_m_valid", 64'(m_valid), 64'(0));
      check("post_rst_counter", 64'(counter), 64'(0));
    end
    m_ready = 1'b0;

    // Recovery after reset
    do_txn(32'h30, 16'h0077, 1'b1, 1, 1'b0);
    check("recover_data_out", 64'(data_out), 64'(8'h77));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
